spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL provide parameter ID_VALUE, default 8'h5A, the constant returned at address 0x0.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, the synchronizer depth for iRxReady and iSPICS (minimum 2).
REQ-003 SHALL have port sysclk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port iReset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port iRxReady  input  1  byte-received flag from the SPI slave, asynchronous to sysclk, held high at least one SPI bit time.
REQ-006 SHALL have port iRx  input  8  received byte, stable while iRxReady is high.
REQ-007 SHALL have port iSPICS  input  1  SPI chip select, active-low, asynchronous.
REQ-008 SHALL have port oTxReady  output  1  one-cycle pulse: oTx holds a new byte for the SPI slave.
REQ-009 SHALL have port oTx  output  8  byte to shift out on MISO; held until the next load.
REQ-010 SHALL have port iStatus  input  64  read-only status; byte n at bits [8n+7:8n] maps to address 0x8+n.
REQ-011 SHALL have port oRegs  output  56  RW registers 0x1..0x7; register k at bits [8(k-1)+7:8(k-1)].
REQ-012 SHALL have port oWrPulse  output  8  bit k pulses one cycle when register k is written; bit 0 is always 0.
REQ-013 SHALL have port oFrameErr  output  1  one-cycle pulse when a write frame ends before its first data byte.

Function
REQ-014 SHALL pass iRxReady and iSPICS through SYNC_STAGES flops each; iRx SHALL be sampled only on a byte strobe.
REQ-015 SHALL generate the byte strobe on the synced iRxReady 0->1 edge, one cycle wide, one strobe per byte.
REQ-016 SHALL generate a frame-end event on the synced iSPICS 0->1 edge.
REQ-017 SHALL decode the command byte as follows: bit7 = 1 means read, 0 means write; bits[3:0] = start address; bits[6:4] are ignored.
REQ-018 SHALL implement FSM states IDLE, WDATA and RDATA.
REQ-019 IDLE, byte strobe, read command: load oTx with the value at the address, pulse oTxReady on the next cycle, increment the address, and go to RDATA.
REQ-020 IDLE, byte strobe, write command: latch the address, clear the data-seen flag, and go to WDATA.
REQ-021 WDATA, byte strobe: write iRx to the register if the address is 0x1..0x7 and pulse oWrPulse[addr]; writes to 0x0 and 0x8..0xF are ignored with no pulse; set the data-seen flag and increment the address.
REQ-022 RDATA, byte strobe: treat the received byte as a dummy, load oTx with the value at the current address, pulse oTxReady, and increment the address.
REQ-023 Address arithmetic SHALL be 4-bit, wrapping 0xF -> 0x0 in both bursts.
REQ-024 Read map: 0x0 = ID_VALUE; 0x1..0x7 = oRegs; 0x8..0xF = iStatus, sampled in the same cycle as the load.
REQ-025 Frame-end in any state SHALL return the FSM to IDLE; if the FSM was in WDATA with the data-seen flag clear, SHALL pulse oFrameErr.
REQ-026 Byte strobe and frame-end in the same cycle: process the byte first, then go to IDLE; oFrameErr is evaluated after the byte is processed.
REQ-027 Byte strobe while synced iSPICS is high SHALL be ignored.
REQ-028 Latency from byte strobe to oTxReady SHALL be exactly 1 cycle; the system SHALL run sysclk >= 16x the SPI clock.
REQ-029 Register writes SHALL take effect on oRegs in the cycle after the strobe, coincident with oWrPulse.

Reset
REQ-030 On iReset high at a sysclk edge: FSM to IDLE; address 0; oRegs = 0; oTx = 0; oTxReady = 0; oWrPulse = 0; oFrameErr = 0.
REQ-031 On iReset, synchronizer flops SHALL load the inactive values (iRxReady sync = 0, iSPICS sync = 1) so no false edge follows reset.
REQ-032 iReset mid-frame SHALL abort the frame; bytes of that frame after reset release SHALL be ignored until the next iSPICS 0->1 -> 1->0 cycle.

Verification
REQ-033 Write burst: CS low, bytes 0x02, 0x11, 0x22 -> oRegs reg2 = 0x11, reg3 = 0x22; oWrPulse bit2 then bit3 pulse.
REQ-034 Read wrap: iStatus[63:56] = 0xC3, CS low, bytes 0x8F, 0x00 -> oTx 0xC3 with oTxReady, then ID_VALUE 0x5A.
REQ-035 RO write: bytes 0x00, 0x77 -> no oWrPulse; readback of 0x0 returns 0x5A.
REQ-036 Abort: CS low, byte 0x05, CS high -> one oFrameErr pulse; reg5 unchanged; next frame decodes its first byte as a command.
REQ-037 Collision: byte strobe and CS rise in the same cycle on a WDATA byte 0x44 at address 0x7 -> reg7 = 0x44, no oFrameErr, FSM in IDLE.
REQ-038 Reset mid-read: iReset during RDATA -> all outputs at reset values; following bytes ignored until CS toggles.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// SPI slave byte stream to register bridge: a command byte picks read/write and a start
// address, then data bytes burst through a 16-entry map with 4-bit auto-increment.
module spi_reg_bridge #(
    parameter logic [7:0]  ID_VALUE    = 8'h5A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        sysclk,
    input  logic        iReset,
    input  logic        iRxReady,
    input  logic [7:0]  iRx,
    input  logic        iSPICS,
    output logic        oTxReady,
    output logic [7:0]  oTx,
    input  logic [63:0] iStatus,
    output logic [55:0] oRegs,
    output logic [7:0]  oWrPulse,
    output logic        oFrameErr
);
    localparam int unsigned FlushW = $clog2(SYNC_STAGES + 1);

    typedef enum logic [1:0] {Idle, WData, RData} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] rxSync, csSync;
    logic                   rxPrev, csPrev;
    logic [FlushW-1:0]      flushCnt;
    logic                   armed;
    logic [3:0]             addr;
    logic                   dataSeen;
    logic [55:0]            regFile;

    logic       rxS, csS, byteStrobe, frameEnd;
    logic [3:0] rdAddr;
    logic [7:0] rdData;
    logic       inWDataAfter, seenAfter;

    assign rxS = rxSync[SYNC_STAGES-1];
    assign csS = csSync[SYNC_STAGES-1];
    // csPrev gates the strobe so a byte landing together with the CS rise is still taken
    assign byteStrobe = rxS & ~rxPrev & ~csPrev & armed;
    assign frameEnd   = csS & ~csPrev;
    assign oRegs      = regFile;

    always_comb begin
        rdAddr = (state == Idle) ? iRx[3:0] : addr;
        if (rdAddr == 4'h0) begin
            rdData = ID_VALUE;
        end else if (!rdAddr[3]) begin
            rdData = regFile[{rdAddr[2:0] - 3'd1, 3'b000} +: 8];
        end else begin
            rdData = iStatus[{rdAddr[2:0], 3'b000} +: 8];
        end

        // Frame-error decision looks at the state as it stands after this cycle's byte
        inWDataAfter = (state == WData);
        seenAfter    = dataSeen;
        if (byteStrobe) begin
            if (state == Idle) begin
                inWDataAfter = ~iRx[7];
                seenAfter    = 1'b0;
            end else if (state == WData) begin
                seenAfter = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (iReset) begin
            rxSync    <= '0;
            csSync    <= '1;
            rxPrev    <= 1'b0;
            csPrev    <= 1'b1;
            flushCnt  <= '0;
            armed     <= 1'b0;
            state     <= Idle;
            addr      <= 4'h0;
            dataSeen  <= 1'b0;
            regFile   <= '0;
            oTx       <= 8'h00;
            oTxReady  <= 1'b0;
            oWrPulse  <= 8'h00;
            oFrameErr <= 1'b0;
        end else begin
            rxSync    <= {rxSync[SYNC_STAGES-2:0], iRxReady};
            csSync    <= {csSync[SYNC_STAGES-2:0], iSPICS};
            rxPrev    <= rxS;
            csPrev    <= csS;
            oTxReady  <= 1'b0;
            oWrPulse  <= 8'h00;
            oFrameErr <= 1'b0;

            // Bytes stay ignored after reset until CS is genuinely seen high
            if (flushCnt != FlushW'(SYNC_STAGES)) begin
                flushCnt <= flushCnt + FlushW'(1);
            end else if (csS) begin
                armed <= 1'b1;
            end

            if (byteStrobe) begin
                case (state)
                    Idle: begin
                        if (iRx[7]) begin
                            oTx      <= rdData;
                            oTxReady <= 1'b1;
                            addr     <= iRx[3:0] + 4'd1;
                            state    <= RData;
                        end else begin
                            addr     <= iRx[3:0];
                            dataSeen <= 1'b0;
                            state    <= WData;
                        end
                    end
                    WData: begin
                        if (addr != 4'h0 && !addr[3]) begin
                            regFile[{addr[2:0] - 3'd1, 3'b000} +: 8] <= iRx;
                            oWrPulse <= 8'd1 << addr[2:0];
                        end
                        dataSeen <= 1'b1;
                        addr     <= addr + 4'd1;
                    end
                    RData: begin
                        oTx      <= rdData;
                        oTxReady <= 1'b1;
                        addr     <= addr + 4'd1;
                    end
                    default: state <= Idle;
                endcase
            end

            if (frameEnd) begin
                state     <= Idle;
                oFrameErr <= inWDataAfter & ~seenAfter;
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: frames are modelled at byte/frame level, expected
// outputs are queued at issue time and popped by an independent output monitor.
module tb_spi_reg_bridge;
    logic        sysclk = 1'b0;
    logic        iReset, iRxReady, iSPICS;
    logic [7:0]  iRx;
    logic [63:0] iStatus;
    logic        oTxReady, oFrameErr;
    logic [7:0]  oTx, oWrPulse;
    logic [55:0] oRegs;

    int checks = 0;
    int errors = 0;

    logic [7:0]  txQ[$];
    logic [15:0] wrQ[$];
    int          errPending = 0;
    logic [7:0]  mRegs[8];

    always #5 sysclk = ~sysclk;

    spi_reg_bridge #(.ID_VALUE(8'h5A), .SYNC_STAGES(2)) dut (
        .sysclk    (sysclk),
        .iReset    (iReset),
        .iRxReady  (iRxReady),
        .iRx       (iRx),
        .iSPICS    (iSPICS),
        .oTxReady  (oTxReady),
        .oTx       (oTx),
        .iStatus   (iStatus),
        .oRegs     (oRegs),
        .oWrPulse  (oWrPulse),
        .oFrameErr (oFrameErr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] readVal(input logic [3:0] a);
        if (a == 4'h0) return 8'h5A;
        if (a < 4'h8) return mRegs[a[2:0]];
        return iStatus[8*(int'(a) - 8) +: 8];
    endfunction

    function automatic logic [55:0] modelRegs();
        return {mRegs[7], mRegs[6], mRegs[5], mRegs[4], mRegs[3], mRegs[2], mRegs[1]};
    endfunction

    // Output monitor
    always @(negedge sysclk) begin
        if (oTxReady === 1'b1) begin
            check("oTxReady expected", 64'(txQ.size() != 0), 64'd1);
            if (txQ.size() != 0) check("oTx", 64'(oTx), 64'(txQ.pop_front()));
        end
        if (oWrPulse !== 8'h00 && !$isunknown(oWrPulse)) begin
            check("oWrPulse expected", 64'(wrQ.size() != 0), 64'd1);
            if (wrQ.size() != 0) begin
                logic [15:0] e;
                int idx;
                e   = wrQ.pop_front();
                idx = int'(e[10:8]);
                check("oWrPulse bit", 64'(oWrPulse), 64'(8'd1 << idx));
                check("oRegs written byte", 64'(oRegs[8*(idx-1) +: 8]), 64'(e[7:0]));
            end
        end
        if (oFrameErr === 1'b1) begin
            check("oFrameErr expected", 64'(errPending != 0), 64'd1);
            if (errPending != 0) errPending--;
        end
    end

    task automatic sendByte(input logic [7:0] b, input bit endFrame);
        @(posedge sysclk); #2;
        iRx      = b;
        iRxReady = 1'b1;
        if (endFrame) iSPICS = 1'b1;
        repeat (8) @(posedge sysclk);
        #2 iRxReady = 1'b0;
        repeat (8) @(posedge sysclk);
    endtask

    // Frame-level reference: read bursts return successive map entries, write bursts
    // store into 0x1..0x7 only, a bare write command is a frame error.
    task automatic doFrame(input logic [7:0] fb[$], input bit collide);
        logic [3:0] a;
        bit         rd;
        @(posedge sysclk); #2 iSPICS = 1'b0;
        repeat (6) @(posedge sysclk);
        rd = fb[0][7];
        a  = fb[0][3:0];
        for (int i = 0; i < fb.size(); i++) begin
            if (rd) begin
                txQ.push_back(readVal(a));
                a = a + 4'd1;
            end else if (i > 0) begin
                if (a >= 4'h1 && a <= 4'h7) begin
                    mRegs[a[2:0]] = fb[i];
                    wrQ.push_back({5'b0, a[2:0], fb[i]});
                end
                a = a + 4'd1;
            end
            sendByte(fb[i], collide && (i == fb.size() - 1));
        end
        if (!rd && fb.size() == 1) errPending++;
        if (!collide) begin
            @(posedge sysclk); #2 iSPICS = 1'b1;
        end
        repeat (8) @(posedge sysclk);
        #2 check("oRegs after frame", 64'(oRegs), 64'(modelRegs()));
    endtask

    task automatic checkResetOutputs();
        check("reset oTx", 64'(oTx), 64'd0);
        check("reset oTxReady", 64'(oTxReady), 64'd0);
        check("reset oRegs", 64'(oRegs), 64'd0);
        check("reset oWrPulse", 64'(oWrPulse), 64'd0);
        check("reset oFrameErr", 64'(oFrameErr), 64'd0);
    endtask

    initial begin
        logic [7:0] fb[$];
        int         n, waited;
        iReset = 1'b1; iRxReady = 1'b0; iSPICS = 1'b1; iRx = 8'h00; iStatus = '0;
        for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
        repeat (3) @(posedge sysclk);
        #1 checkResetOutputs();
        #1 iReset = 1'b0;
        repeat (6) @(posedge sysclk);

        // Write burst
        fb = {8'h02, 8'h11, 8'h22};
        doFrame(fb, 1'b0);
        // Read wraps 0xF -> 0x0
        iStatus = {8'hC3, 24'h0, $urandom};
        fb = {8'h8F, 8'h00};
        doFrame(fb, 1'b0);
        // Write to the ID location is dropped
        fb = {8'h00, 8'h77};
        doFrame(fb, 1'b0);
        fb = {8'h80};
        doFrame(fb, 1'b0);
        // Bare write command then CS rise
        fb = {8'h05};
        doFrame(fb, 1'b0);
        fb = {8'h85, 8'hFF};
        doFrame(fb, 1'b0);
        // Last data byte arrives together with CS rise
        fb = {8'h07, 8'h44};
        doFrame(fb, 1'b1);
        fb = {8'h87};
        doFrame(fb, 1'b0);

        for (int f = 0; f < 25; f++) begin
            n  = $urandom_range(1, 5);
            fb = {};
            for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
            iStatus = {$urandom, $urandom};
            doFrame(fb, 1'b0);
        end

        // Reset in the middle of a read burst; remaining bytes of that frame are dropped
        @(posedge sysclk); #2 iSPICS = 1'b0;
        repeat (6) @(posedge sysclk);
        txQ.push_back(readVal(4'h1));
        sendByte(8'h81, 1'b0);
        txQ.push_back(readVal(4'h2));
        sendByte(8'h00, 1'b0);
        @(posedge sysclk); #2 iReset = 1'b1;
        @(posedge sysclk); #1 checkResetOutputs();
        #1 iReset = 1'b0;
        for (int i = 0; i < 8; i++) mRegs[i] = 8'h00;
        sendByte(8'h81, 1'b0);
        sendByte(8'h02, 1'b0);
        sendByte(8'h33, 1'b0);
        @(posedge sysclk); #2 iSPICS = 1'b1;
        repeat (8) @(posedge sysclk);
        #2 check("oRegs after ignored bytes", 64'(oRegs), 64'd0);
        fb = {8'h03, 8'hAB};
        doFrame(fb, 1'b0);
        fb = {8'h83, 8'h00};
        doFrame(fb, 1'b0);

        waited = 0;
        while ((txQ.size() != 0 || wrQ.size() != 0 || errPending != 0) && waited < 200) begin
            @(posedge sysclk);
            waited++;
        end
        check("txQ drained", 64'(txQ.size()), 64'd0);
        check("wrQ drained", 64'(wrQ.size()), 64'd0);
        check("frame errors drained", 64'(errPending), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
